memory_access_stage: RTL

Memory stage of the pipelined RISC-V core, directly downstream of the execute-to-memory pipeline register. Takes the registered ALU result (effective address), store data, func3 and memory enables, runs a request/grant/valid handshake with the data memory, formats sub-word loads and stores, and stalls the upstream pipeline until the access completes. Produces the formatted load word for the memory-to-writeback register.

---
 rtl/memory_access_stage.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/memory_access_stage.sv
// Memory stage: request/grant/valid data-memory handshake, sub-word load/store formatting, upstream stall.
// Optional build macro MEMORY_STAGE_MISALIGN_TRAP_EN: misaligned half/word accesses skip the bus and pulse misaligned.
module memory_access_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 15  // 1..255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] aluResult,
    input  logic [31:0] storeData,
    input  logic [2:0]  func3,
    input  logic        memoryReadEnable,
    input  logic        memoryWriteEnable,
    output logic        stall,
    output logic        dmemRequest,
    output logic        dmemWrite,
    output logic [31:0] dmemAddress,
    output logic [31:0] dmemWriteData,
    output logic [3:0]  dmemByteEnable,
    input  logic        dmemGrant,
    input  logic        dmemReadValid,
    input  logic [31:0] dmemReadData,
    output logic [31:0] loadData,
    output logic        loadValid,
    output logic        busError,
    output logic        misaligned,
    output logic [1:0]  debug_state
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        REQUEST   = 2'd1,
        WAIT_READ = 2'd2,
        DONE      = 2'd3
    } state_t;

    localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

    state_t      state;
    logic        access_store;
    logic [2:0]  access_func3;
    logic [1:0]  access_offset;
    logic [7:0]  wait_count;
    logic [7:0]  wait_next;
    logic        access_byte;
    logic        access_half;
    logic        misalign_hit;
    logic [3:0]  lane_enable;
    logic [31:0] store_word;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] formatted_load;

    // Handshake: dmemRequest holds address/data/enables stable until the cycle dmemGrant is seen high.
    assign stall = !reset && (((state == IDLE) && (memoryReadEnable || memoryWriteEnable))
                              || (state == REQUEST) || (state == WAIT_READ));
    assign debug_state = state;
    assign wait_next = (wait_count == 8'hFF) ? wait_count : wait_count + 8'd1;

    // 100/101 only mean unsigned sub-word for loads; a store with those codes is a word store.
    always_comb begin
        access_byte = (func3 == 3'b000) || (!memoryWriteEnable && (func3 == 3'b100));
        access_half = (func3 == 3'b001) || (!memoryWriteEnable && (func3 == 3'b101));
        lane_enable = 4'b1111;
        store_word  = storeData;
        if (access_byte) begin
            lane_enable = 4'b0001 << aluResult[1:0];
            store_word  = {4{storeData[7:0]}};
        end else if (access_half) begin
            lane_enable = aluResult[1] ? 4'b1100 : 4'b0011;
            store_word  = {2{storeData[15:0]}};
        end
    end

`ifdef MEMORY_STAGE_MISALIGN_TRAP_EN
    assign misalign_hit = access_half ? aluResult[0] : (!access_byte && (aluResult[1:0] != 2'b00));
`else
    assign misalign_hit = 1'b0;
`endif

    always_comb begin
        case (access_offset)
            2'd0:    sel_byte = dmemReadData[7:0];
            2'd1:    sel_byte = dmemReadData[15:8];
            2'd2:    sel_byte = dmemReadData[23:16];
            default: sel_byte = dmemReadData[31:24];
        endcase
        sel_half = access_offset[1] ? dmemReadData[31:16] : dmemReadData[15:0];
        case (access_func3)
            3'b000:  formatted_load = {{24{sel_byte[7]}}, sel_byte};
            3'b001:  formatted_load = {{16{sel_half[15]}}, sel_half};
            3'b100:  formatted_load = {24'd0, sel_byte};
            3'b101:  formatted_load = {16'd0, sel_half};
            default: formatted_load = dmemReadData;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            access_store   <= 1'b0;
            access_func3   <= 3'd0;
            access_offset  <= 2'd0;
            wait_count     <= 8'd0;
            dmemRequest    <= 1'b0;
            dmemWrite      <= 1'b0;
            dmemAddress    <= 32'd0;
            dmemWriteData  <= 32'd0;
            dmemByteEnable <= 4'd0;
            loadData       <= 32'd0;
            loadValid      <= 1'b0;
            busError       <= 1'b0;
            misaligned     <= 1'b0;
        end else begin
            loadValid  <= 1'b0;
            misaligned <= 1'b0;
            case (state)
                IDLE: begin
                    if (memoryReadEnable || memoryWriteEnable) begin
                        access_store  <= memoryWriteEnable;
                        access_func3  <= func3;
                        access_offset <= aluResult[1:0];
                        if (misalign_hit) begin
                            misaligned <= 1'b1;
                            state      <= DONE;
                        end else begin
                            dmemRequest    <= 1'b1;
                            dmemWrite      <= memoryWriteEnable;
                            dmemAddress    <= {aluResult[31:2], 2'b00};
                            dmemWriteData  <= memoryWriteEnable ? store_word : 32'd0;
                            dmemByteEnable <= lane_enable;
                            state          <= REQUEST;
                        end
                    end
                end
                REQUEST: begin
                    if (dmemGrant) begin
                        dmemRequest <= 1'b0;
                        wait_count  <= 8'd0;
                        state       <= access_store ? DONE : WAIT_READ;
                    end
                end
                WAIT_READ: begin
                    if (dmemReadValid) begin
                        loadData  <= formatted_load;
                        loadValid <= 1'b1;
                        state     <= DONE;
                    end else if (wait_next == TIMEOUT_LIMIT) begin
                        loadData  <= 32'd0;
                        loadValid <= 1'b1;
                        busError  <= 1'b1;
                        state     <= DONE;
                    end else begin
                        wait_count <= wait_next;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
